// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Signed operands are handled as magnitudes plus a latched result sign.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 sign;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
    // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude
    return (sm && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mag_b[i]) partial = partial + (mag_a << i);
    end
    acc_sum = acc + partial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      sign    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mag_a <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
      mag_b <= magnitude(b, signed_mode);
      sign  <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc   <= '0;
      cnt   <= CW'(N);
    end else if (state == RUN) begin
      acc   <= acc_sum;
      mag_a <= mag_a << BITS_PER_CYCLE;
      mag_b <= mag_b >> BITS_PER_CYCLE;
      cnt   <= cnt - 1'b1;
      if (last) product <= sign ? (~acc_sum + 1'b1) : acc_sum;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: one 16x16 instance retiring 1 bit/cycle and one retiring 4 bits/cycle,
// compared against plain-arithmetic products.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0, sm1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1;
  logic [31:0] p1;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [31:0] p4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(p1)
  );

  seq_shift_add_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic sm);
    longint r;
    if (sm) r = longint'($signed(x)) * longint'($signed(y));
    else    r = longint'({16'b0, x}) * longint'({16'b0, y});
    return r[31:0];
  endfunction

  // Called at the negedge just after the accept edge; poke drives a stray start mid-RUN.
  task automatic wait1(input logic [31:0] exp, input logic [31:0] prev, input bit poke, input string tag);
    int n = 1;
    while (done1 !== 1'b1 && n < 40) begin
      check({tag, " busy1"}, busy1, 1);
      check({tag, " hold1"}, p1, prev);
      start1 = poke && (n == 3);
      @(negedge clk);
      n++;
    end
    start1 = 1'b0;
    check({tag, " latency1"}, n, 17);
    check({tag, " product1"}, p1, exp);
    check({tag, " busy1 at done"}, busy1, 0);
  endtask

  task automatic mul1(input logic [15:0] x, input logic [15:0] y, input logic sm, input bit poke, input string tag);
    logic [31:0] exp, prev;
    exp  = model(x, y, sm);
    prev = p1;
    @(negedge clk);
    a1 = x; b1 = y; sm1 = sm; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); sm1 = ~sm;
    wait1(exp, prev, poke, tag);
    @(negedge clk);
    check({tag, " single done1"}, done1, 0);
    check({tag, " product1 held"}, p1, exp);
  endtask

  task automatic wait4(input logic [31:0] exp, input logic [31:0] prev, input string tag);
    int n = 1;
    while (done4 !== 1'b1 && n < 40) begin
      check({tag, " busy4"}, busy4, 1);
      check({tag, " hold4"}, p4, prev);
      @(negedge clk);
      n++;
    end
    check({tag, " latency4"}, n, 5);
    check({tag, " product4"}, p4, exp);
  endtask

  task automatic launch4(input logic [15:0] x, input logic [15:0] y, input logic sm);
    a4 = x; b4 = y; sm4 = sm; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); sm4 = ~sm;
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic        rs;
    logic [31:0] e1, e2;

    repeat (2) @(negedge clk);
    check("reset busy1", busy1, 0);
    check("reset done1", done1, 0);
    check("reset product1", p1, 0);
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset product4", p4, 0);
    rst = 1'b0;

    mul1(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "uns max");
    check("uns max value", p1, 32'hFFFE0001);
    mul1(16'hFFFD, 16'h0005, 1'b1, 1'b0, "sgn -3*5");
    check("sgn -3*5 value", p1, 32'hFFFFFFF1);
    mul1(16'h8000, 16'h8000, 1'b1, 1'b0, "sgn min*min");
    check("sgn min*min value", p1, 32'h40000000);
    mul1(16'h8000, 16'h8000, 1'b0, 1'b0, "uns 8000^2");
    mul1(16'hFFFD, 16'h0005, 1'b0, 1'b0, "uns fffd*5");
    check("uns fffd*5 value", p1, 32'h0004FFF1);
    mul1(16'h0000, 16'h8000, 1'b1, 1'b0, "sgn zero");
    check("sgn zero not -0", p1, 0);
    mul1(16'hFFFF, 16'h0001, 1'b1, 1'b0, "sgn -1*1");
    mul1(16'h1234, 16'h00FF, 1'b0, 1'b1, "start ignored");

    // Abort mid-RUN: outputs clear next cycle, no late done.
    @(negedge clk);
    a1 = 16'h7FFF; b1 = 16'h7FFF; sm1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy1", busy1, 0);
    check("rst done1", done1, 0);
    check("rst product1", p1, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no done after abort", done1, 0);
    end
    mul1(16'h00C8, 16'hFF38, 1'b1, 1'b0, "after rst");

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom); ry = 16'($urandom); rs = 1'($urandom);
      mul1(rx, ry, rs, 1'b0, "rand1");
    end

    // Four bits per cycle, including back-to-back start in DONE.
    @(negedge clk);
    e1 = model(16'd1234, 16'd5678, 1'b0);
    launch4(16'd1234, 16'd5678, 1'b0);
    wait4(e1, 32'h0, "bpc4 1234*5678");
    check("bpc4 value", p4, 32'h006AE9BC);
    e2 = model(16'h8001, 16'h7FFF, 1'b1);
    launch4(16'h8001, 16'h7FFF, 1'b1);
    wait4(e2, e1, "bpc4 b2b");
    @(negedge clk);
    check("bpc4 single done", done4, 0);
    check("bpc4 held", p4, e2);

    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom); ry = 16'($urandom); rs = 1'($urandom);
      e1 = p4;
      e2 = model(rx, ry, rs);
      launch4(rx, ry, rs);
      wait4(e2, e1, "rand4");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
